// File: rtl/vector_sum_pkg.sv
// Shared constants and helpers for the vector_sum_pipe block: mode encoding,
// tree geometry derived from the lane count, and the final narrowing step.
package vector_sum_pkg;

  localparam logic MODE_ELEM = 1'b0;
  localparam logic MODE_RED  = 1'b1;

  // Ceiling log2 usable in constant expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Adder-tree levels above the a_i+b_i level.
  function automatic int tree_lvls(input int lanes);
    return clog2(lanes);
  endfunction

  // Tree word width: one carry bit for a_i+b_i plus one per pairing level,
  // so no partial sum can overflow.
  function automatic int tree_w(input int width, input int lanes);
    return width + 1 + clog2(lanes);
  endfunction

  // End-to-end latency, identical for both modes.
  function automatic int lat(input int add_lat, input int lanes);
    return add_lat * (1 + clog2(lanes));
  endfunction

  // Narrow a wide result to 'width' bits: wrap, or clamp to all-ones when
  // sat is set and any bit above 'width' is non-zero.
  function automatic logic [63:0] sat_trunc(input logic [63:0] value,
                                            input int width, input bit sat);
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    if (sat && ((value & ~mask) != 64'd0)) return mask;
    return value & mask;
  endfunction

endpackage

// File: rtl/vector_sum_pipe_if.sv
// Stream bundle for vector_sum_pipe: input beat (A, B, mode) with valid/ready
// and output beat (sum, mode) with valid/ready. Lane i sits at [i*WIDTH +: WIDTH].
interface vector_sum_pipe_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
) ();
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_a;
  logic [LANES*WIDTH-1:0] in_b;
  logic                   in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*WIDTH-1:0] out_sum;
  logic                   out_mode;

  // Source/sink side (drives beats in, consumes results).
  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_mode
  );

  // Block side.
  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_mode
  );
endinterface

// File: rtl/delay_fixed_en.sv
// Fixed-depth shift register with a shared enable. The valid bit is cleared
// by reset; the data word is not, since it is only meaningful under valid.
module delay_fixed_en #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         vld_i,
  input  logic [W-1:0] dat_i,
  output logic         vld_o,
  output logic [W-1:0] dat_o
);
  logic         vld_q [DEPTH];
  logic [W-1:0] dat_q [DEPTH];

  // Valid line: cleared on reset, shifts only when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) vld_q[i] <= 1'b0;
    end else if (en_i) begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  // Data line: shifts in lockstep with the valid line.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      dat_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) dat_q[i] <= dat_q[i-1];
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/vector_sum_pipe.sv
// LANES-wide vector adder with an optional reduce mode. Level 0 forms a_i+b_i;
// the elementwise result is delayed to match the adder tree so both modes
// share one latency. The whole pipe advances together and stalls on
// backpressure; empty slots travel as invalid beats.
module vector_sum_pipe
  import vector_sum_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 1,
  parameter int SAT     = 0
) (
  input logic              clock,
  input logic              reset,
  vector_sum_pipe_if.slave bus
);
  localparam int LVLS = tree_lvls(LANES);
  localparam int TW   = tree_w(WIDTH, LANES);
  localparam int LW   = WIDTH + 1;
  localparam int DW   = LANES * LW + 1;   // lane sums plus the mode bit on top
  localparam int BAL  = ADD_LAT * LVLS;

  logic                   adv;
  logic                   out_valid_w;
  logic                   out_mode_w;
  logic [LANES*WIDTH-1:0] out_sum_w;

  assign adv          = !out_valid_w || bus.out_ready;
  assign bus.in_ready = adv || reset;

  // Level 0: per-lane a_i + b_i with the carry kept.
  logic [LANES*LW-1:0] sum0_d;
  always_comb begin
    sum0_d = '0;
    for (int i = 0; i < LANES; i++)
      sum0_d[i*LW +: LW] = LW'(bus.in_a[i*WIDTH +: WIDTH]) + LW'(bus.in_b[i*WIDTH +: WIDTH]);
  end

  logic          vld0_q;
  logic [DW-1:0] s0_q;
  delay_fixed_en #(.W(DW), .DEPTH(ADD_LAT)) u_lvl0 (
    .clk_i(clock), .rst_i(reset), .en_i(adv),
    .vld_i(bus.in_valid), .dat_i({bus.in_mode, sum0_d}),
    .vld_o(vld0_q), .dat_o(s0_q)
  );

  // Elementwise balancing line; also carries the beat's valid and mode.
  logic          vld_e_q;
  logic [DW-1:0] el_q;
  delay_fixed_en #(.W(DW), .DEPTH(BAL)) u_bal (
    .clk_i(clock), .rst_i(reset), .en_i(adv),
    .vld_i(vld0_q), .dat_i(s0_q),
    .vld_o(vld_e_q), .dat_o(el_q)
  );

  // Tree nodes in heap order: node n (1..LANES-1) at [(n-1)*TW +: TW], root is
  // node 1. Children 2n/2n+1 at or above LANES are level-0 lane sums.
  logic [(LANES-1)*TW-1:0] tree_d;
  logic [(LANES-1)*TW-1:0] tree_q;
  logic [LVLS:1]           vld_t_q;

  // Pairwise sums for every tree node, fed from the previous level's registers.
  always_comb begin
    logic [TW-1:0] lhs;
    logic [TW-1:0] rhs;
    tree_d = '0;
    for (int n = 1; n < LANES; n++) begin
      if (2*n >= LANES) begin
        lhs = TW'(s0_q[(2*n-LANES)*LW +: LW]);
        rhs = TW'(s0_q[(2*n+1-LANES)*LW +: LW]);
      end else begin
        lhs = tree_q[(2*n-1)*TW +: TW];
        rhs = tree_q[(2*n)*TW +: TW];
      end
      tree_d[(n-1)*TW +: TW] = lhs + rhs;
    end
  end

  for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
    localparam int N   = LANES >> k;
    localparam int OFS = (N - 1) * TW;
    logic vld_in;
    if (k == 1) begin : g_first
      assign vld_in = vld0_q;
    end else begin : g_next
      assign vld_in = vld_t_q[k-1];
    end
    delay_fixed_en #(.W(N*TW), .DEPTH(ADD_LAT)) u_dly (
      .clk_i(clock), .rst_i(reset), .en_i(adv),
      .vld_i(vld_in), .dat_i(tree_d[OFS +: N*TW]),
      .vld_o(vld_t_q[k]), .dat_o(tree_q[OFS +: N*TW])
    );
  end

  // Both paths carry the same valid by construction.
  assign out_valid_w = vld_e_q & vld_t_q[LVLS];

  // Output select and narrowing; idle output reads as zero.
  always_comb begin
    out_sum_w  = '0;
    out_mode_w = 1'b0;
    if (out_valid_w) begin
      out_mode_w = el_q[DW-1];
      for (int i = 0; i < LANES; i++)
        out_sum_w[i*WIDTH +: WIDTH] = WIDTH'(sat_trunc(64'(el_q[i*LW +: LW]), WIDTH, SAT != 0));
      if (el_q[DW-1] == MODE_RED) begin
        out_sum_w = '0;
        out_sum_w[WIDTH-1:0] = WIDTH'(sat_trunc(64'(tree_q[TW-1:0]), WIDTH, SAT != 0));
      end
    end
  end

  assign bus.out_valid = out_valid_w;
  assign bus.out_mode  = out_mode_w;
  assign bus.out_sum   = out_sum_w;
endmodule

// File: tb/tb_vector_sum_pipe.sv
// Bench for vector_sum_pipe (LANES=4, WIDTH=16, ADD_LAT=1): a wrapping and a
// saturating instance share all stimulus; a scoreboard queue holds the
// hand-computed results for both and a monitor compares each consumed beat.
module tb_vector_sum_pipe;
  import vector_sum_pkg::*;

  typedef struct { logic [63:0] a; logic [63:0] b; logic m; logic [63:0] e0; logic [63:0] e1; } vec_t;
  typedef struct { logic [63:0] e0; logic [63:0] e1; logic m; } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  int   acc_q[$];
  int   pop_q[$];
  vec_t tbl[12];
  exp_t cur;
  logic [63:0] snap0, snap1;

  vector_sum_pipe_if #(.LANES(4), .WIDTH(16)) bus0 ();
  vector_sum_pipe_if #(.LANES(4), .WIDTH(16)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_a      = bus0.in_a;
  assign bus1.in_b      = bus0.in_b;
  assign bus1.in_mode   = bus0.in_mode;
  assign bus1.out_ready = bus0.out_ready;

  vector_sum_pipe #(.LANES(4), .WIDTH(16), .ADD_LAT(1), .SAT(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  vector_sum_pipe #(.LANES(4), .WIDTH(16), .ADD_LAT(1), .SAT(1)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] p4(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every consumed output beat is popped from the scoreboard.
  always @(negedge clock) begin
    if (!reset && bus0.out_valid === 1'b1 && bus0.out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_beat", 64'(bus0.out_valid), 64'd0);
      end else begin
        cur = sb_q.pop_front();
        chk("sum_wrap", bus0.out_sum, cur.e0);
        chk("sum_sat", bus1.out_sum, cur.e1);
        chk("mode_wrap", 64'(bus0.out_mode), 64'(cur.m));
        chk("mode_sat", 64'(bus1.out_mode), 64'(cur.m));
        chk("valid_sat", 64'(bus1.out_valid), 64'd1);
        pop_q.push_back(cyc);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the beat is accepted.
  task automatic send(input vec_t v);
    bit   done;
    exp_t e;
    done = 1'b0;
    bus0.in_a = v.a; bus0.in_b = v.b; bus0.in_mode = v.m; bus0.in_valid = 1'b1;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clock);
      if (bus0.in_ready === 1'b1) begin
        e.e0 = v.e0; e.e1 = v.e1; e.m = v.m;
        sb_q.push_back(e);
        acc_q.push_back(cyc);
        done = 1'b1;
      end
      @(posedge clock); #1;
    end
    bus0.in_valid = 1'b0;
    if (!done) chk("accept_timeout", 64'(bus0.in_ready), 64'd1);
  endtask

  task automatic wait_pops(input int n);
    for (int t = 0; t < 60 && pop_q.size() < n; t++) @(posedge clock);
    #1;
    if (pop_q.size() < n) chk("pop_timeout", 64'(pop_q.size()), 64'(n));
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 60 && sb_q.size() != 0; t++) @(posedge clock);
    #1;
    if (sb_q.size() != 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    // Lane order in p4 is lane0..lane3; e0 = wrapping, e1 = saturating result.
    tbl[0]  = '{p4(16'd1, 16'd2, 16'd3, 16'd4), p4(16'd10, 16'd20, 16'd30, 16'd40), MODE_ELEM,
                p4(16'd11, 16'd22, 16'd33, 16'd44), p4(16'd11, 16'd22, 16'd33, 16'd44)};
    tbl[1]  = '{p4(16'hFFFF, 16'h0100, 16'h8000, 16'h7FFF), p4(16'h0002, 16'h0200, 16'h8000, 16'h0001), MODE_ELEM,
                p4(16'h0001, 16'h0300, 16'h0000, 16'h8000), p4(16'hFFFF, 16'h0300, 16'hFFFF, 16'h8000)};
    tbl[2]  = '{p4(16'd1, 16'd2, 16'd3, 16'd4), p4(16'd5, 16'd6, 16'd7, 16'd8), MODE_RED,
                p4(16'd36, 16'd0, 16'd0, 16'd0), p4(16'd36, 16'd0, 16'd0, 16'd0)};
    tbl[3]  = '{p4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), p4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), MODE_RED,
                p4(16'hFFF8, 16'd0, 16'd0, 16'd0), p4(16'hFFFF, 16'd0, 16'd0, 16'd0)};
    tbl[4]  = '{p4(16'd1, 16'd1, 16'd1, 16'd1), p4(16'd2, 16'd3, 16'd4, 16'd5), MODE_ELEM,
                p4(16'd3, 16'd4, 16'd5, 16'd6), p4(16'd3, 16'd4, 16'd5, 16'd6)};
    tbl[5]  = '{p4(16'd1, 16'd1, 16'd1, 16'd1), p4(16'd2, 16'd3, 16'd4, 16'd5), MODE_RED,
                p4(16'd18, 16'd0, 16'd0, 16'd0), p4(16'd18, 16'd0, 16'd0, 16'd0)};
    tbl[6]  = '{p4(16'd100, 16'd200, 16'd300, 16'd400), p4(16'd1, 16'd2, 16'd3, 16'd4), MODE_ELEM,
                p4(16'd101, 16'd202, 16'd303, 16'd404), p4(16'd101, 16'd202, 16'd303, 16'd404)};
    tbl[7]  = '{p4(16'd100, 16'd200, 16'd300, 16'd400), p4(16'd1, 16'd2, 16'd3, 16'd4), MODE_RED,
                p4(16'd1010, 16'd0, 16'd0, 16'd0), p4(16'd1010, 16'd0, 16'd0, 16'd0)};
    tbl[8]  = '{p4(16'hFFFF, 16'hFFFF, 16'd0, 16'd0), p4(16'd1, 16'd0, 16'd0, 16'd0), MODE_ELEM,
                p4(16'h0000, 16'hFFFF, 16'd0, 16'd0), p4(16'hFFFF, 16'hFFFF, 16'd0, 16'd0)};
    tbl[9]  = '{p4(16'h8000, 16'h8000, 16'd0, 16'd0), p4(16'd0, 16'd0, 16'd0, 16'd0), MODE_RED,
                p4(16'h0000, 16'd0, 16'd0, 16'd0), p4(16'hFFFF, 16'd0, 16'd0, 16'd0)};
    tbl[10] = '{p4(16'd7, 16'd7, 16'd7, 16'd7), p4(16'd0, 16'd0, 16'd0, 16'd0), MODE_ELEM,
                p4(16'd7, 16'd7, 16'd7, 16'd7), p4(16'd7, 16'd7, 16'd7, 16'd7)};
    tbl[11] = '{p4(16'h4000, 16'h4000, 16'h4000, 16'h3FFF), p4(16'd0, 16'd0, 16'd0, 16'd0), MODE_RED,
                p4(16'hFFFF, 16'd0, 16'd0, 16'd0), p4(16'hFFFF, 16'd0, 16'd0, 16'd0)};

    bus0.in_valid = 1'b0; bus0.in_a = '0; bus0.in_b = '0; bus0.in_mode = 1'b0;
    bus0.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_valid_sat", 64'(bus1.out_valid), 64'd0);
    chk("rst_out_mode", 64'(bus0.out_mode), 64'd0);
    chk("rst_out_sum", bus0.out_sum, 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Single elementwise beat: latency 3, one-cycle valid
    acc_q.delete(); pop_q.delete();
    send(tbl[0]);
    wait_pops(1);
    if (pop_q.size() > 0) chk("lat_elem", 64'(pop_q[0] - acc_q[0]), 64'd3);
    @(negedge clock);
    chk("single_valid_pulse", 64'(bus0.out_valid), 64'd0);
    @(posedge clock); #1;

    // Overflow and reduce vectors back to back
    acc_q.delete(); pop_q.delete();
    for (int i = 1; i <= 3; i++) send(tbl[i]);
    wait_pops(3);
    if (pop_q.size() > 1) chk("lat_reduce", 64'(pop_q[1] - acc_q[1]), 64'd3);
    wait_drain();

    // Alternating modes at full rate
    acc_q.delete(); pop_q.delete();
    for (int i = 4; i <= 11; i++) send(tbl[i]);
    wait_pops(8);
    if (pop_q.size() == 8) begin
      chk("alt_lat", 64'(pop_q[0] - acc_q[0]), 64'd3);
      for (int i = 1; i < 8; i++) chk("alt_rate", 64'(pop_q[i] - pop_q[i-1]), 64'd1);
    end
    wait_drain();

    // Backpressure: 5 stalled cycles with a full pipe
    acc_q.delete(); pop_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send(tbl[i]);
      end
      begin
        repeat (4) @(posedge clock);
        #1 bus0.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clock);
          if (k == 0) begin snap0 = bus0.out_sum; snap1 = bus1.out_sum; end
          chk("stall_in_ready", 64'(bus0.in_ready), 64'd0);
          chk("stall_out_valid", 64'(bus0.out_valid), 64'd1);
          if (k > 0) begin
            chk("stall_hold_wrap", bus0.out_sum, snap0);
            chk("stall_hold_sat", bus1.out_sum, snap1);
          end
        end
        @(posedge clock); #1 bus0.out_ready = 1'b1;
      end
    join
    wait_pops(6);
    if (pop_q.size() == 6) begin
      chk("stall_gap", 64'(pop_q[1] - pop_q[0]), 64'd6);
      for (int i = 2; i < 6; i++) chk("drain_rate", 64'(pop_q[i] - pop_q[i-1]), 64'd1);
    end
    wait_drain();

    // Reset with two beats in flight
    send(tbl[4]);
    send(tbl[5]);
    reset = 1'b1;
    sb_q.delete();
    @(negedge clock);
    chk("rst_mid_in_ready", 64'(bus0.in_ready), 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("rst_mid_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_mid_out_valid_sat", 64'(bus1.out_valid), 64'd0);
    chk("rst_mid_out_sum", bus0.out_sum, 64'd0);
    chk("rst_mid_out_mode", 64'(bus0.out_mode), 64'd0);
    repeat (6) @(posedge clock);
    #1;
    acc_q.delete(); pop_q.delete();
    send(tbl[6]);
    wait_pops(1);
    if (pop_q.size() > 0) chk("lat_after_reset", 64'(pop_q[0] - acc_q[0]), 64'd3);
    wait_drain();
    chk("final_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vector_sum_pipe.md
Name: vector_sum_pipe

Overview:
Parametrised successor of the fixed 4-lane, 16-bit vector adder. Adds two LANES-wide vectors of WIDTH-bit unsigned words with a registered adder latency and delay-line balancing. Adds a per-beat reduce mode that sums all 2*LANES operands through an adder tree, plus a valid/ready handshake with stall. Sits between DFC stream sources and sinks in generated top-levels.

Parameters:
LANES, 4, lane count; power of two, >= 2
WIDTH, 16, bits per lane word (unsigned)
ADD_LAT, 1, register stages per adder level; >= 1
SAT, 0, 0 = wrap (truncate) results; 1 = saturate to all-ones on overflow

Ports:
clock  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_a  in  LANES*WIDTH  vector A; lane i at bits [i*WIDTH +: WIDTH]
in_b  in  LANES*WIDTH  vector B, same packing
in_mode  in  1  0 = elementwise, 1 = reduce; sampled with the beat
out_valid  out  1  output beat valid
out_ready  in  1  sink accepts the output beat
out_sum  out  LANES*WIDTH  result vector, same packing
out_mode  out  1  mode of the beat on out_sum

Behaviour:
- Latency L = ADD_LAT*(1 + log2(LANES)) cycles, identical for both modes; LANES=4, ADD_LAT=1 gives L=3.
- Pipeline has L stages; each holds a valid bit, mode bit and data.
- Global enable adv = !out_valid || out_ready; in_ready = adv (combinational).
- adv=1: all stages shift one place; stage 0 loads in_valid/in_mode/data. Beat accepted iff in_valid && in_ready.
- adv=0: every stage holds; out_sum/out_valid/out_mode stable until out_ready.
- Bubbles are not collapsed; an empty stage moves as an invalid slot.
- Elementwise: lane i = a_i + b_i at WIDTH+1 bits, then wrap (SAT=0) or saturate to 2^WIDTH-1 (SAT=1). Level-0 adder outputs pass through enabled delay lines of ADD_LAT*log2(LANES) cycles so they exit with reduce results.
- Reduce: level 0 forms a_i+b_i; log2(LANES) further levels add pairs. Tree width is WIDTH+1+log2(LANES), so there is no intermediate overflow. Final value goes to lane 0, wrapped or saturated to WIDTH bits; lanes 1..LANES-1 = 0.
- Mode may change beat to beat; no drain or flush needed.
- Reset: all valid bits, out_valid, out_mode and out_sum = 0 on the cycle after reset is high. in_ready = 1 while reset is high.
- Reset mid-stream discards every in-flight beat; no output beat appears for data accepted before reset.
- in_valid while in_ready=0: no accept; source must hold its data (standard valid/ready).
- Simultaneous output consume and input accept in the same cycle is legal; full throughput is 1 beat/cycle when out_ready is held high.

Decomposition:
- Package vector_sum_pkg holds:
  - mode encoding constants MODE_ELEM=0 and MODE_RED=1;
  - constant function clog2;
  - derived constants TREE_LVLS=clog2(LANES), TREE_W=WIDTH+1+TREE_LVLS, LAT=ADD_LAT*(1+TREE_LVLS);
  - function sat_trunc(value, SAT) for final narrowing.
- One sub-module, delay_fixed_en: parametrised width/depth shift register with enable and synchronous reset of its valid bit. Used for the elementwise balancing path and the mode/valid sidelines.

Test Plan:
- Elementwise, LANES=4, WIDTH=16, SAT=0, out_ready=1: A={1,2,3,4}, B={10,20,30,40} -> after 3 cycles out_sum={11,22,33,44}, out_mode=0, out_valid for exactly 1 cycle.
- Overflow: lane0 0xFFFF+0x0002 -> 0x0001 with SAT=0; 0xFFFF with SAT=1.
- Reduce: A={1,2,3,4}, B={5,6,7,8} -> lane0=36, lanes1..3=0. All operands 0xFFFF -> lane0=0xFFF8 (SAT=0) or 0xFFFF (SAT=1).
- Back-to-back alternating modes for 8 beats at full rate -> 8 outputs in order, 1/cycle, correct per-beat modes.
- Backpressure: out_ready low for 5 cycles with a full pipeline -> in_ready=0, out_sum stable, no loss or duplication; on release, remaining beats drain 1/cycle.
- Reset asserted with 2 beats in flight -> out_valid=0 next cycle, no stale beats afterward, next accepted beat appears after exactly 3 cycles.
